scr1_tb_ahb_bus_watchdog: RTL
=============================

// Module: scr1_tb_ahb_bus_watchdog
// PURPOSE
//  Parametrised N-channel AHB-Lite bus watchdog/monitor for SCR1 testbenches; replaces per-bench
//  ad-hoc watchdog counters. Passively observes CH_NUM master ports (e.g. imem, dmem, DMA),
//  tracks address/data phases, counts completed transfers, error responses and wait states,
//  and raises sticky per-channel stall and global hang flags used by the run-tests loop.
// PARAMETERS
//  CH_NUM      2        number of monitored AHB channels (1..8)
//  AW          32       haddr width
//  CNT_W       32       width of transfer/error counters (saturating)
//  STALL_LIMIT 1024     max consecutive wait states in one data phase before ch_stall
//  HANG_LIMIT  2000000  max cycles with no completed transfer on any channel before hang
// PORTS
//  clk           in   1              bench clock
//  rst           in   1              async reset, active-high
//  mon_en        in   1              1: counting enabled; 0: counters/watchdogs frozen
//  clr           in   1              sync clear of all counters and sticky flags
//  ch_htrans     in   CH_NUM*2       per-channel HTRANS
//  ch_haddr      in   CH_NUM*AW      per-channel HADDR
//  ch_hsize      in   CH_NUM*3       per-channel HSIZE
//  ch_hready     in   CH_NUM         per-channel HREADY
//  ch_hresp      in   CH_NUM         per-channel HRESP (1 = ERROR)
//  xfer_cnt      out  CH_NUM*CNT_W   completed transfers per channel
//  err_cnt       out  CH_NUM*CNT_W   transfers completed with HRESP=ERROR
//  stall_max     out  CH_NUM*16      longest observed wait-state run (saturates at 16'hFFFF)
//  ch_stall      out  CH_NUM         sticky: data phase exceeded STALL_LIMIT waits
//  hang          out  1              sticky: global progress watchdog expired
//  viol          out  CH_NUM         sticky protocol violation (only with SCR1_TB_AHB_WDOG_CHK_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, all channel FSMs IDLE, progress counter 0.
//  - Address phase accepted when htrans[1]==1 (NONSEQ/SEQ) && hready==1 in the same cycle.
//  - Per-channel FSM: IDLE -> DPHASE on accept; DPHASE with hready=1: completion;
//    if another accept in same cycle stay DPHASE (pipelined back-to-back), else -> IDLE.
//    DPHASE with hready=0: wait_cnt++ (saturating at STALL_LIMIT), stay DPHASE.
//  - Completion: xfer_cnt++; err_cnt++ if hresp=1; stall_max=max(stall_max,wait_cnt); wait_cnt=0.
//  - ch_stall set in cycle wait_cnt reaches STALL_LIMIT; remains set until clr or rst.
//  - Progress counter: +1 per cycle, reset to 0 on any channel completion; hang set when
//    it reaches HANG_LIMIT; counter then holds.
//  - Counting (xfer/err/stall_max/wait/progress) gated by mon_en; FSMs always track phases
//    so re-enabling mid-transfer stays aligned.
//  - All counters saturate at all-ones, never wrap.
//  - clr has priority over any same-cycle event; FSM state is not affected by clr.
//  - Outputs are registered: a completion in cycle N is visible in xfer_cnt in cycle N+1.
//  - rst asserted mid-transfer: immediate return to reset state; the following transfer is
//    counted from its next accepted address phase.
// CONFIGURATION
//  SCR1_TB_AHB_WDOG_CHK_EN defined: per-channel protocol checker sets viol[i] on
//   (a) accepted address misaligned for hsize (half: haddr[0]!=0; word: haddr[1:0]!=0),
//   (b) hsize > 3'b010, (c) htrans==BUSY, (d) hresp=1 seen with hready=1 without a preceding
//   hresp=1/hready=0 cycle (two-cycle ERROR rule).
//  Not defined: viol tied to 0, checker logic absent.
// STRUCTURE
//  - scr1_tb_ahb_wdog_pkg: FSM state enum (IDLE, DPHASE), HTRANS/HSIZE encodings (from
//    scr1_ahb.svh), stall_max width constant.
//  - Sub-module scr1_tb_ahb_wdog_ch: one channel (FSM, counters, checker), generated CH_NUM
//    times; top holds progress counter, hang and output packing.
// TESTING
//  1 Reset: rst=1 mid-DPHASE -> all outputs 0, next single NONSEQ on ch0 gives xfer_cnt[0]=1.
//  2 Back-to-back: ch0 4 NONSEQ, hready=1 always -> xfer_cnt[0]=4 one cycle after last
//    data phase, stall_max[0]=0.
//  3 Wait states: ch1 one read with 7 hready=0 cycles -> stall_max[1]=7; STALL_LIMIT=8 and
//    8 waits -> ch_stall[1]=1, ch_stall[0]=0.
//  4 Error: ch0 ERROR response (hresp=1 for 2 cycles) -> err_cnt[0]=1, xfer_cnt[0]=1.
//  5 Hang: HANG_LIMIT=100, channels IDLE 100 cycles -> hang=1 on cycle 100; clr -> hang=0,
//    counter restarts; clr with same-cycle completion -> xfer_cnt=0.
//  6 With SCR1_TB_AHB_WDOG_CHK_EN: word access at haddr=0x202 -> viol[0]=1; without macro -> 0.

Source files
------------

// File: rtl/scr1_tb_ahb_wdog_pkg.sv
// Shared types and AHB encodings for the SCR1 testbench AHB bus watchdog.
// Optional protocol checker is enabled by SCR1_TB_AHB_WDOG_CHK_EN.
package scr1_tb_ahb_wdog_pkg;

    typedef enum logic {
        WD_IDLE   = 1'b0,
        WD_DPHASE = 1'b1
    } wdog_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int unsigned STALL_MAX_W = 16;

    function automatic logic misaligned(input logic [2:0] hsize,
                                        input logic [1:0] addr);
        misaligned = 1'b0;
        case (hsize)
            HSIZE_HALF: misaligned = addr[0];
            HSIZE_WORD: misaligned = |addr;
            default:    misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scr1_tb_ahb_wdog_ch.sv
// One monitored AHB channel: phase FSM, saturating counters, stall flag and
// optional protocol checker (SCR1_TB_AHB_WDOG_CHK_EN).
module scr1_tb_ahb_wdog_ch
    import scr1_tb_ahb_wdog_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mon_en_i,
    input  logic                   clr_i,
    input  logic [1:0]             htrans_i,
    input  logic [AW-1:0]          haddr_i,
    input  logic [2:0]             hsize_i,
    input  logic                   hready_i,
    input  logic                   hresp_i,
    output logic [CNT_W-1:0]       xfer_cnt_o,
    output logic [CNT_W-1:0]       err_cnt_o,
    output logic [STALL_MAX_W-1:0] stall_max_o,
    output logic                   stall_o,
    output logic                   viol_o,
    output logic                   done_o
);

    localparam int unsigned WCNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WLIM = WCNT_W'(STALL_LIMIT);

    wdog_state_e            state_q, state_d;
    logic [CNT_W-1:0]       xfer_q, xfer_d;
    logic [CNT_W-1:0]       err_q, err_d;
    logic [STALL_MAX_W-1:0] smax_q, smax_d;
    logic [WCNT_W-1:0]      wait_q, wait_d;
    logic                   stall_q, stall_d;
    logic                   accept;
    logic                   dphase;
    logic                   done;
    logic [31:0]            wait_w;
    logic [STALL_MAX_W-1:0] wait16;

    assign accept = htrans_i[1] & hready_i;
    assign dphase = (state_q == WD_DPHASE);
    assign done   = dphase & hready_i;
    assign wait_w = 32'(wait_q);
    assign wait16 = (wait_w > 32'hFFFF) ? 16'hFFFF : wait_w[15:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WD_IDLE:   if (accept) state_d = WD_DPHASE;
            WD_DPHASE: if (hready_i) state_d = accept ? WD_DPHASE : WD_IDLE;
            default:   state_d = WD_IDLE;
        endcase
    end

    always_comb begin
        xfer_d  = xfer_q;
        err_d   = err_q;
        smax_d  = smax_q;
        wait_d  = wait_q;
        stall_d = stall_q;
        if (clr_i) begin
            xfer_d  = '0;
            err_d   = '0;
            smax_d  = '0;
            wait_d  = '0;
            stall_d = 1'b0;
        end else begin
            // wait run always closes on completion so a frozen monitor stays aligned
            if (done) begin
                wait_d = '0;
            end else if (mon_en_i && dphase && wait_q != WLIM) begin
                wait_d = wait_q + WCNT_W'(1);
            end
            if (mon_en_i && done) begin
                if (xfer_q != '1) xfer_d = xfer_q + CNT_W'(1);
                if (hresp_i && err_q != '1) err_d = err_q + CNT_W'(1);
                if (wait16 > smax_q) smax_d = wait16;
            end
            if (wait_d == WLIM) stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WD_IDLE;
            xfer_q  <= '0;
            err_q   <= '0;
            smax_q  <= '0;
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            xfer_q  <= xfer_d;
            err_q   <= err_d;
            smax_q  <= smax_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

`ifdef SCR1_TB_AHB_WDOG_CHK_EN
    logic viol_q, viol_d;
    logic perr_q;
    logic bad;

    // ERROR must be preceded by an hresp=1/hready=0 cycle
    assign bad = (accept & (misaligned(hsize_i, haddr_i[1:0])
                            | (hsize_i > HSIZE_WORD)))
               | (htrans_i == HTRANS_BUSY)
               | (hresp_i & hready_i & ~perr_q);

    always_comb begin
        viol_d = viol_q;
        if (clr_i) viol_d = 1'b0;
        else if (bad) viol_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            viol_q <= viol_d;
            perr_q <= hresp_i & ~hready_i;
        end
    end

    assign viol_o = viol_q;
`else
    logic unused_chk;
    assign unused_chk = ^{haddr_i, hsize_i};
    assign viol_o     = 1'b0;
`endif

    assign xfer_cnt_o  = xfer_q;
    assign err_cnt_o   = err_q;
    assign stall_max_o = smax_q;
    assign stall_o     = stall_q;
    assign done_o      = done;

endmodule

// File: rtl/scr1_tb_ahb_bus_watchdog.sv
// N-channel passive AHB-Lite watchdog: per-channel monitors plus global hang timer.
// Protocol checker built only with SCR1_TB_AHB_WDOG_CHK_EN defined.
module scr1_tb_ahb_bus_watchdog
    import scr1_tb_ahb_wdog_pkg::*;
#(
    parameter int unsigned CH_NUM      = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned HANG_LIMIT  = 2000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mon_en,
    input  logic                            clr,
    input  logic [CH_NUM*2-1:0]             ch_htrans,
    input  logic [CH_NUM*AW-1:0]            ch_haddr,
    input  logic [CH_NUM*3-1:0]             ch_hsize,
    input  logic [CH_NUM-1:0]               ch_hready,
    input  logic [CH_NUM-1:0]               ch_hresp,
    output logic [CH_NUM*CNT_W-1:0]         xfer_cnt,
    output logic [CH_NUM*CNT_W-1:0]         err_cnt,
    output logic [CH_NUM*STALL_MAX_W-1:0]   stall_max,
    output logic [CH_NUM-1:0]               ch_stall,
    output logic                            hang,
    output logic [CH_NUM-1:0]               viol
);

    localparam int unsigned PW = $clog2(HANG_LIMIT + 1);
    localparam logic [PW-1:0] HLIM = PW'(HANG_LIMIT);

    logic [CH_NUM-1:0] done;
    logic [PW-1:0]     prog_q, prog_d;
    logic              hang_q, hang_d;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        scr1_tb_ahb_wdog_ch #(
            .AW          (AW),
            .CNT_W       (CNT_W),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .mon_en_i    (mon_en),
            .clr_i       (clr),
            .htrans_i    (ch_htrans[g*2 +: 2]),
            .haddr_i     (ch_haddr[g*AW +: AW]),
            .hsize_i     (ch_hsize[g*3 +: 3]),
            .hready_i    (ch_hready[g]),
            .hresp_i     (ch_hresp[g]),
            .xfer_cnt_o  (xfer_cnt[g*CNT_W +: CNT_W]),
            .err_cnt_o   (err_cnt[g*CNT_W +: CNT_W]),
            .stall_max_o (stall_max[g*STALL_MAX_W +: STALL_MAX_W]),
            .stall_o     (ch_stall[g]),
            .viol_o      (viol[g]),
            .done_o      (done[g])
        );
    end

    always_comb begin
        prog_d = prog_q;
        hang_d = hang_q;
        if (clr) begin
            prog_d = '0;
            hang_d = 1'b0;
        end else begin
            if (|done) prog_d = '0;
            else if (mon_en && prog_q != HLIM) prog_d = prog_q + PW'(1);
            if (prog_d == HLIM) hang_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_q <= '0;
            hang_q <= 1'b0;
        end else begin
            prog_q <= prog_d;
            hang_q <= hang_d;
        end
    end

    assign hang = hang_q;

endmodule
